// File: rtl/p1v_rst_pkg.sv
// Shared types for the staged reset sequencer: FSM states, reset-cause codes
// and the priority encoder that picks the cause on entry to ASSERT.
package p1v_rst_pkg;

   typedef enum logic [2:0] {
      ASSERT,
      WAIT_LOCK,
      STRETCH,
      RELEASE,
      RUN
   } state_t;

   localparam logic [2:0] CAUSE_POR  = 3'b000;
   localparam logic [2:0] CAUSE_EXT  = 3'b001;
   localparam logic [2:0] CAUSE_WDOG = 3'b010;
   localparam logic [2:0] CAUSE_SW   = 3'b011;
   localparam logic [2:0] CAUSE_LOCK = 3'b100;

   // External reset outranks watchdog, which outranks software; lock loss is last.
   function automatic logic [2:0] pick_cause(input logic ext_req,
                                             input logic wdog_req,
                                             input logic sw_req);
      if (ext_req) begin
         return CAUSE_EXT;
      end else if (wdog_req) begin
         return CAUSE_WDOG;
      end else if (sw_req) begin
         return CAUSE_SW;
      end
      return CAUSE_LOCK;
   endfunction

endpackage

// File: rtl/p1v_sync.sv
// Multi-flop bit synchroniser for asynchronous inputs into the clk_cog domain.
// All stages clear to 0 under reset.
module p1v_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_cog,
   input  logic res,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk_cog or posedge res) begin
      if (res) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/p1v_rst_seq.sv
// Reset sequencer: merges external, software, watchdog and lock-loss requests,
// stretches the reset after PLL lock and releases the domain resets in order.
module p1v_rst_seq #(
   parameter int NUM_DOMAINS    = 2,
   parameter int SYNC_STAGES    = 2,
   parameter int STRETCH_CYCLES = 1024,
   parameter int STAGE_GAP      = 16,
   parameter int WDOG_LIMIT     = 16777216,
   parameter int CNT_W          = 24
) (
   input  logic                   clk_cog,
   input  logic                   res,
   input  logic                   ext_resn,
   input  logic                   sw_res,
   input  logic                   pll_lock,
   input  logic                   wdog_en,
   input  logic                   wdog_kick,
   output logic [NUM_DOMAINS-1:0] nres_out,
   output logic                   busy,
   output logic [2:0]             reset_cause
);

   import p1v_rst_pkg::*;

   localparam int IDX_W = $clog2(NUM_DOMAINS + 1);
   localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
   localparam logic [CNT_W-1:0] WDOG_LAST    = CNT_W'(WDOG_LIMIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);

   state_t                 state, state_n;
   logic [CNT_W-1:0]       cnt, cnt_n;
   logic [IDX_W-1:0]       idx, idx_n;
   logic                   lock_seen, lock_seen_n;
   logic [NUM_DOMAINS-1:0] nres_n;
   logic                   busy_n;
   logic [2:0]             cause_n;
   logic                   ext_resn_s, pll_lock_s;
   logic                   wdog_to, lock_loss, req;

   p1v_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (
      .clk_cog (clk_cog),
      .res     (res),
      .d       (ext_resn),
      .q       (ext_resn_s)
   );

   p1v_sync #(.STAGES(SYNC_STAGES)) u_sync_pll (
      .clk_cog (clk_cog),
      .res     (res),
      .d       (pll_lock),
      .q       (pll_lock_s)
   );

   // A kick in the limit cycle suppresses the timeout, so the kick wins.
   assign wdog_to   = (state == RUN) && wdog_en && !wdog_kick && (cnt == WDOG_LAST);
   assign lock_loss = lock_seen && !pll_lock_s;
   assign req       = !ext_resn_s || sw_res || wdog_to || lock_loss;

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      idx_n       = idx;
      lock_seen_n = lock_seen;
      nres_n      = nres_out;
      cause_n     = reset_cause;
      if (req) begin
         state_n     = ASSERT;
         cnt_n       = '0;
         idx_n       = '0;
         nres_n      = '0;
         lock_seen_n = 1'b0;
         if (state != ASSERT) begin
            cause_n = pick_cause(!ext_resn_s, wdog_to, sw_res);
         end
      end else begin
         case (state)
            ASSERT: begin
               state_n     = WAIT_LOCK;
               lock_seen_n = 1'b0;
            end
            WAIT_LOCK: begin
               if (pll_lock_s) begin
                  state_n     = STRETCH;
                  cnt_n       = '0;
                  lock_seen_n = 1'b1;
               end
            end
            STRETCH: begin
               if (cnt == STRETCH_LAST) begin
                  cnt_n     = '0;
                  nres_n[0] = 1'b1;
                  if (NUM_DOMAINS == 1) begin
                     state_n = RUN;
                  end else begin
                     state_n = RELEASE;
                     idx_n   = IDX_W'(1);
                  end
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            RELEASE: begin
               if (cnt == GAP_LAST) begin
                  cnt_n = '0;
                  idx_n = idx + IDX_W'(1);
                  for (int k = 0; k < NUM_DOMAINS; k++) begin
                     if (idx == IDX_W'(k)) begin
                        nres_n[k] = 1'b1;
                     end
                  end
                  if (idx == LAST_IDX) begin
                     state_n = RUN;
                  end
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            RUN: begin
               if (wdog_kick || !wdog_en) begin
                  cnt_n = '0;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            default: begin
               state_n = ASSERT;
            end
         endcase
      end
      busy_n = (state_n != RUN);
   end

   always_ff @(posedge clk_cog or posedge res) begin
      if (res) begin
         state       <= ASSERT;
         cnt         <= '0;
         idx         <= '0;
         lock_seen   <= 1'b0;
         nres_out    <= '0;
         busy        <= 1'b1;
         reset_cause <= CAUSE_POR;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         idx         <= idx_n;
         lock_seen   <= lock_seen_n;
         nres_out    <= nres_n;
         busy        <= busy_n;
         reset_cause <= cause_n;
      end
   end

endmodule

// File: tb/tb_p1v_rst_seq.sv
// Directed self-checking bench for p1v_rst_seq: power-on release, watchdog,
// software/external resets, PLL lock loss and asynchronous reset.
module tb_p1v_rst_seq;

   localparam int ND = 3;
   localparam int SS = 2;

   // Sync flops start at 0, so ASSERT is left at edge SS+1, STRETCH entered at
   // edge SS+2, and domains then release 8, 12 and 16 edges later.
   localparam int REL0 = 12;
   localparam int REL1 = 16;
   localparam int REL2 = 20;

   logic          clk_cog = 1'b0;
   logic          res;
   logic          ext_resn;
   logic          sw_res;
   logic          pll_lock;
   logic          wdog_en;
   logic          wdog_kick;
   logic [ND-1:0] nres_out;
   logic          busy;
   logic [2:0]    reset_cause;

   int checks = 0;
   int errors = 0;

   p1v_rst_seq #(
      .NUM_DOMAINS    (ND),
      .SYNC_STAGES    (SS),
      .STRETCH_CYCLES (8),
      .STAGE_GAP      (4),
      .WDOG_LIMIT     (20),
      .CNT_W          (8)
   ) dut (
      .clk_cog     (clk_cog),
      .res         (res),
      .ext_resn    (ext_resn),
      .sw_res      (sw_res),
      .pll_lock    (pll_lock),
      .wdog_en     (wdog_en),
      .wdog_kick   (wdog_kick),
      .nres_out    (nres_out),
      .busy        (busy),
      .reset_cause (reset_cause)
   );

   always #5 clk_cog = ~clk_cog;

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_cog);
         #1;
      end
   endtask

   task automatic test_reset();
      res = 1'b1; ext_resn = 1'b1; sw_res = 1'b0; pll_lock = 1'b1;
      wdog_en = 1'b0; wdog_kick = 1'b0;
      tick(3);
      checks++;
      if (nres_out !== 3'b000) begin
         errors++; $display("[TB] FAIL reset_nres: got %b expected %b", nres_out, 3'b000);
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_busy: got %b expected %b", busy, 1'b1);
      end
      checks++;
      if (reset_cause !== 3'b000) begin
         errors++; $display("[TB] FAIL reset_cause: got %b expected %b", reset_cause, 3'b000);
      end
      res = 1'b0;
   endtask

   task automatic test_power_on();
      logic [ND-1:0] exp_n;
      for (int e = 1; e <= REL2; e++) begin
         tick(1);
         exp_n = {(e >= REL2), (e >= REL1), (e >= REL0)};
         checks++;
         if (nres_out !== exp_n) begin
            errors++; $display("[TB] FAIL por_nres edge %0d: got %b expected %b", e, nres_out, exp_n);
         end
         checks++;
         if (busy !== (e < REL2)) begin
            errors++; $display("[TB] FAIL por_busy edge %0d: got %b expected %b", e, busy, (e < REL2));
         end
      end
      checks++;
      if (reset_cause !== 3'b000) begin
         errors++; $display("[TB] FAIL por_cause: got %b expected %b", reset_cause, 3'b000);
      end
   endtask

   task automatic test_watchdog();
      int drops;
      wdog_en = 1'b1;
      tick(19);
      checks++;
      if (nres_out !== 3'b111) begin
         errors++; $display("[TB] FAIL wdog_before_limit: got %b expected %b", nres_out, 3'b111);
      end
      tick(1);
      checks++;
      if (nres_out !== 3'b000) begin
         errors++; $display("[TB] FAIL wdog_timeout: got %b expected %b", nres_out, 3'b000);
      end
      checks++;
      if (reset_cause !== 3'b010) begin
         errors++; $display("[TB] FAIL wdog_cause: got %b expected %b", reset_cause, 3'b010);
      end
      wdog_en = 1'b0;
      tick(17);
      checks++;
      if (nres_out !== 3'b011) begin
         errors++; $display("[TB] FAIL wdog_rerelease_gap: got %b expected %b", nres_out, 3'b011);
      end
      tick(1);
      checks++;
      if (nres_out !== 3'b111 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL wdog_rerelease: got %b/%b expected %b/%b", nres_out, busy, 3'b111, 1'b0);
      end
      // Kick lands exactly in the limit cycle, then regular kicks every 10.
      wdog_en = 1'b1;
      tick(19);
      wdog_kick = 1'b1;
      tick(1);
      checks++;
      if (nres_out !== 3'b111) begin
         errors++; $display("[TB] FAIL wdog_kick_at_limit: got %b expected %b", nres_out, 3'b111);
      end
      drops = 0;
      for (int i = 0; i < 200; i++) begin
         wdog_kick = (i % 10 == 9);
         tick(1);
         if (nres_out !== 3'b111) drops++;
      end
      checks++;
      if (drops !== 0) begin
         errors++; $display("[TB] FAIL wdog_kicked_200: got %0d resets expected %0d", drops, 0);
      end
      wdog_en = 1'b0;
      wdog_kick = 1'b0;
   endtask

   task automatic test_sw_reset();
      sw_res = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         checks++;
         if (nres_out !== 3'b000) begin
            errors++; $display("[TB] FAIL sw_hold cycle %0d: got %b expected %b", k, nres_out, 3'b000);
         end
      end
      checks++;
      if (reset_cause !== 3'b011) begin
         errors++; $display("[TB] FAIL sw_cause: got %b expected %b", reset_cause, 3'b011);
      end
      sw_res = 1'b0;
      tick(10);
      checks++;
      if (nres_out !== 3'b001) begin
         errors++; $display("[TB] FAIL sw_rel0: got %b expected %b", nres_out, 3'b001);
      end
      tick(7);
      checks++;
      if (nres_out !== 3'b011) begin
         errors++; $display("[TB] FAIL sw_rel1: got %b expected %b", nres_out, 3'b011);
      end
      tick(1);
      checks++;
      if (nres_out !== 3'b111 || busy !== 1'b0 || reset_cause !== 3'b011) begin
         errors++; $display("[TB] FAIL sw_rel2: got %b/%b/%b expected %b/%b/%b",
                            nres_out, busy, reset_cause, 3'b111, 1'b0, 3'b011);
      end
   endtask

   task automatic test_ext_sw();
      ext_resn = 1'b0;
      sw_res = 1'b1;
      tick(1);
      checks++;
      if (nres_out !== 3'b000 || reset_cause !== 3'b011) begin
         errors++; $display("[TB] FAIL ext_sw_entry: got %b/%b expected %b/%b", nres_out, reset_cause, 3'b000, 3'b011);
      end
      tick(2);
      checks++;
      if (reset_cause !== 3'b011) begin
         errors++; $display("[TB] FAIL ext_sw_cause_held: got %b expected %b", reset_cause, 3'b011);
      end
      ext_resn = 1'b1;
      sw_res = 1'b0;
      tick(19);
      checks++;
      if (nres_out !== 3'b011) begin
         errors++; $display("[TB] FAIL ext_sw_rel1: got %b expected %b", nres_out, 3'b011);
      end
      tick(1);
      checks++;
      if (nres_out !== 3'b111 || reset_cause !== 3'b011) begin
         errors++; $display("[TB] FAIL ext_sw_rel2: got %b/%b expected %b/%b", nres_out, reset_cause, 3'b111, 3'b011);
      end
   endtask

   task automatic test_ext_alone();
      ext_resn = 1'b0;
      tick(2);
      checks++;
      if (nres_out !== 3'b111) begin
         errors++; $display("[TB] FAIL ext_latency_early: got %b expected %b", nres_out, 3'b111);
      end
      tick(1);
      checks++;
      if (nres_out !== 3'b000 || reset_cause !== 3'b001) begin
         errors++; $display("[TB] FAIL ext_entry: got %b/%b expected %b/%b", nres_out, reset_cause, 3'b000, 3'b001);
      end
      ext_resn = 1'b1;
      tick(19);
      checks++;
      if (nres_out !== 3'b011) begin
         errors++; $display("[TB] FAIL ext_rel1: got %b expected %b", nres_out, 3'b011);
      end
      tick(1);
      checks++;
      if (nres_out !== 3'b111 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL ext_rel2: got %b/%b expected %b/%b", nres_out, busy, 3'b111, 1'b0);
      end
   endtask

   task automatic test_lock_loss();
      sw_res = 1'b1;
      tick(1);
      sw_res = 1'b0;
      tick(10);
      checks++;
      if (nres_out !== 3'b001) begin
         errors++; $display("[TB] FAIL lock_rel0: got %b expected %b", nres_out, 3'b001);
      end
      tick(1);
      pll_lock = 1'b0;
      tick(2);
      checks++;
      if (nres_out !== 3'b001) begin
         errors++; $display("[TB] FAIL lock_loss_latency: got %b expected %b", nres_out, 3'b001);
      end
      tick(1);
      checks++;
      if (nres_out !== 3'b000 || reset_cause !== 3'b100) begin
         errors++; $display("[TB] FAIL lock_loss_entry: got %b/%b expected %b/%b", nres_out, reset_cause, 3'b000, 3'b100);
      end
      tick(10);
      checks++;
      if (nres_out !== 3'b000 || busy !== 1'b1) begin
         errors++; $display("[TB] FAIL lock_wait: got %b/%b expected %b/%b", nres_out, busy, 3'b000, 1'b1);
      end
      pll_lock = 1'b1;
      tick(10);
      checks++;
      if (nres_out !== 3'b000) begin
         errors++; $display("[TB] FAIL lock_restart_early: got %b expected %b", nres_out, 3'b000);
      end
      tick(1);
      checks++;
      if (nres_out !== 3'b001) begin
         errors++; $display("[TB] FAIL lock_restart_rel0: got %b expected %b", nres_out, 3'b001);
      end
      tick(8);
      checks++;
      if (nres_out !== 3'b111 || busy !== 1'b0 || reset_cause !== 3'b100) begin
         errors++; $display("[TB] FAIL lock_restart_rel2: got %b/%b/%b expected %b/%b/%b",
                            nres_out, busy, reset_cause, 3'b111, 1'b0, 3'b100);
      end
   endtask

   task automatic test_async_reset();
      #3;
      res = 1'b1;
      #1;
      checks++;
      if (nres_out !== 3'b000 || busy !== 1'b1 || reset_cause !== 3'b000) begin
         errors++; $display("[TB] FAIL async_reset: got %b/%b/%b expected %b/%b/%b",
                            nres_out, busy, reset_cause, 3'b000, 1'b1, 3'b000);
      end
      #2;
      res = 1'b0;
      tick(REL0 - 1);
      checks++;
      if (nres_out !== 3'b000) begin
         errors++; $display("[TB] FAIL async_rel_early: got %b expected %b", nres_out, 3'b000);
      end
      tick(1);
      checks++;
      if (nres_out !== 3'b001) begin
         errors++; $display("[TB] FAIL async_rel0: got %b expected %b", nres_out, 3'b001);
      end
      tick(REL2 - REL0);
      checks++;
      if (nres_out !== 3'b111 || busy !== 1'b0 || reset_cause !== 3'b000) begin
         errors++; $display("[TB] FAIL async_rel2: got %b/%b/%b expected %b/%b/%b",
                            nres_out, busy, reset_cause, 3'b111, 1'b0, 3'b000);
      end
   endtask

   initial begin
      test_reset();
      test_power_on();
      test_watchdog();
      test_sw_reset();
      test_ext_sw();
      test_ext_alone();
      test_lock_loss();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
